// File: rtl/mac_accumulator.sv
// Sums bursts of unsigned product beats into a one-deep valid/ready result register.
// Optional MAC_ACCUMULATOR_SATURATE_EN: clamp the sum at all-ones instead of wrapping.
module mac_accumulator #(
  parameter int unsigned P_WIDTH   = 6,
  parameter int unsigned ACC_WIDTH = 10,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_an_i,
  input  logic                 reset_i,
  input  logic                 prod_valid_i,
  input  logic [P_WIDTH-1:0]   prod_data_i,
  input  logic                 prod_last_i,
  output logic                 stall_o,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic [ACC_WIDTH-1:0] acc_data_o,
  output logic [CNT_WIDTH-1:0] acc_count_o,
  output logic                 overflow_o
);

  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_d;
  logic [ACC_WIDTH-1:0] data_d;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 oflow_d;

  logic                 accept;
  logic [SUM_WIDTH-1:0] sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] beat_acc;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 beat_ovf;

  // Backpressure only when a held result is not being drained this cycle.
  assign stall_o = acc_valid_o & ~acc_ready_i;
  assign accept  = prod_valid_i & ~stall_o;

  // Running values including the current beat.
  always_comb begin
    sum      = SUM_WIDTH'(acc_q) + SUM_WIDTH'(prod_data_i);
    carry    = sum[ACC_WIDTH];
    beat_acc = ACC_WIDTH'(prod_data_i);
    beat_cnt = CNT_WIDTH'(1);
    beat_ovf = 1'b0;
    if (state_q == S_ACCUM) begin
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      beat_acc = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
      beat_acc = sum[ACC_WIDTH-1:0];
`endif
      beat_cnt = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      beat_ovf = ovf_q | carry;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = acc_valid_o;
    data_d  = acc_data_o;
    count_d = acc_count_o;
    oflow_d = overflow_o;

    if (acc_valid_o && acc_ready_i) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      acc_d = beat_acc;
      cnt_d = beat_cnt;
      ovf_d = beat_ovf;
      if (prod_last_i) begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        data_d  = beat_acc;
        count_d = beat_cnt;
        oflow_d = beat_ovf;
      end else begin
        state_d = S_ACCUM;
      end
    end

    if (reset_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      data_d  = '0;
      count_d = '0;
      oflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_an_i) begin
    if (!reset_an_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_valid_o <= 1'b0;
      acc_data_o  <= '0;
      acc_count_o <= '0;
      overflow_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_valid_o <= valid_d;
      acc_data_o  <= data_d;
      acc_count_o <= count_d;
      overflow_o  <= oflow_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios plus randomized bursts
// compared against a burst-level sum model.
module tb_mac_accumulator;

  localparam int unsigned P_WIDTH   = 6;
  localparam int unsigned ACC_WIDTH = 10;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned ACC_MAX   = (1 << ACC_WIDTH) - 1;
  localparam int unsigned CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk_i = 1'b0;
  logic                 reset_an_i;
  logic                 reset_i;
  logic                 prod_valid_i;
  logic [P_WIDTH-1:0]   prod_data_i;
  logic                 prod_last_i;
  logic                 stall_o;
  logic                 acc_valid_o;
  logic                 acc_ready_i;
  logic [ACC_WIDTH-1:0] acc_data_o;
  logic [CNT_WIDTH-1:0] acc_count_o;
  logic                 overflow_o;

  mac_accumulator #(
    .P_WIDTH  (P_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .reset_an_i  (reset_an_i),
    .reset_i     (reset_i),
    .prod_valid_i(prod_valid_i),
    .prod_data_i (prod_data_i),
    .prod_last_i (prod_last_i),
    .stall_o     (stall_o),
    .acc_valid_o (acc_valid_o),
    .acc_ready_i (acc_ready_i),
    .acc_data_o  (acc_data_o),
    .acc_count_o (acc_count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: the open burst is a list of beats; the result is its plain sum.
  int unsigned beats[$];
  bit          m_valid;
  int unsigned m_data;
  int unsigned m_cnt;
  bit          m_ovf;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    beats.delete();
    m_valid = 1'b0;
    m_data  = 0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(acc_valid_o), 32'(m_valid));
    chk({tag, ".data"},  32'(acc_data_o),  m_data);
    chk({tag, ".count"}, 32'(acc_count_o), m_cnt);
    chk({tag, ".ovf"},   32'(overflow_o),  32'(m_ovf));
  endtask

  // One clock: drive inputs, check stall, clock, update model, check outputs.
  task automatic cycle(input string tag, input bit v, input int unsigned d,
                       input bit l, input bit r);
    bit          accept;
    longint unsigned total;
    prod_valid_i = v;
    prod_data_i  = P_WIDTH'(d);
    prod_last_i  = l;
    acc_ready_i  = r;
    #1;
    chk({tag, ".stall"}, 32'(stall_o), 32'(m_valid && !r));
    accept = v && !(m_valid && !r);
    @(posedge clk_i);
    if (m_valid && r) m_valid = 1'b0;
    if (accept) begin
      beats.push_back(d);
      if (l) begin
        total = 0;
        foreach (beats[i]) total += beats[i];
        m_cnt = (beats.size() > CNT_MAX) ? CNT_MAX : beats.size();
        m_ovf = (total > ACC_MAX);
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        m_data = (total > ACC_MAX) ? ACC_MAX : int'(total);
`else
        m_data = int'(total % (ACC_MAX + 1));
`endif
        m_valid = 1'b1;
        beats.delete();
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic sync_reset(input string tag);
    prod_valid_i = 1'b0;
    reset_i      = 1'b1;
    @(posedge clk_i);
    model_clear();
    #1;
    check_outputs(tag);
    reset_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(acc_valid_o), 0);
    chk({tag, ".data"},  32'(acc_data_o),  0);
    chk({tag, ".count"}, 32'(acc_count_o), 0);
    chk({tag, ".ovf"},   32'(overflow_o),  0);
    chk({tag, ".stall"}, 32'(stall_o),     0);
  endtask

  initial begin
    int unsigned exp_big;
    reset_an_i   = 1'b0;
    reset_i      = 1'b0;
    prod_valid_i = 1'b0;
    prod_data_i  = '0;
    prod_last_i  = 1'b0;
    acc_ready_i  = 1'b1;
    model_clear();
    #2;
    check_all_zero("por");
    @(posedge clk_i);
    #1;
    reset_an_i = 1'b1;

    // Three-beat burst 10+20+45.
    cycle("b3_0", 1, 10, 0, 1);
    cycle("b3_1", 1, 20, 0, 1);
    cycle("b3_2", 1, 45, 1, 1);
    chk("b3.data",  32'(acc_data_o),  75);
    chk("b3.count", 32'(acc_count_o), 3);
    chk("b3.valid", 32'(acc_valid_o), 1);
    cycle("b3_idle", 0, 0, 0, 1);
    chk("b3.pulse", 32'(acc_valid_o), 0);

    // Single-beat burst.
    cycle("s1", 1, 33, 1, 1);
    chk("s1.data",  32'(acc_data_o),  33);
    chk("s1.count", 32'(acc_count_o), 1);
    cycle("s1_idle", 0, 0, 0, 1);

    // 23 x 45 = 1035: count saturates, sum overflows.
    for (int i = 0; i < 23; i++) cycle("ovf", 1, 45, i == 22, 1);
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    exp_big = 1023;
`else
    exp_big = 11;
`endif
    chk("ovf.data",  32'(acc_data_o),  exp_big);
    chk("ovf.count", 32'(acc_count_o), 15);
    chk("ovf.flag",  32'(overflow_o),  1);
    cycle("ovf_idle", 0, 0, 0, 1);

    // Backpressure: result 12 held while beat 9 waits, then both move in one cycle.
    cycle("bp_0", 1, 5, 0, 1);
    cycle("bp_1", 1, 7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold", 1, 9, 1, 0);
      chk("bp.stall_hold", 32'(stall_o), 1);
      chk("bp.data_hold",  32'(acc_data_o), 12);
      chk("bp.count_hold", 32'(acc_count_o), 2);
    end
    cycle("bp_go", 1, 9, 1, 1);
    chk("bp.valid_new", 32'(acc_valid_o), 1);
    chk("bp.data_new",  32'(acc_data_o),  9);
    cycle("bp_idle", 0, 0, 0, 1);

    // Back-to-back single-beat bursts at full rate.
    for (int i = 1; i <= 3; i++) begin
      cycle("b2b", 1, i, 1, 1);
      chk("b2b.valid", 32'(acc_valid_o), 1);
      chk("b2b.data",  32'(acc_data_o),  i);
    end
    cycle("b2b_idle", 0, 0, 0, 1);

    // Mid-burst synchronous clear.
    cycle("mr_0", 1, 8, 0, 1);
    cycle("mr_1", 1, 9, 0, 1);
    sync_reset("mr_sync");
    cycle("mr_2", 1, 4, 1, 1);
    chk("mr.data",  32'(acc_data_o),  4);
    chk("mr.count", 32'(acc_count_o), 1);

    // Mid-burst asynchronous reset, with a result held to prove it is dropped.
    cycle("ma_0", 1, 8, 0, 0);
    cycle("ma_1", 1, 9, 0, 0);
    reset_an_i = 1'b0;
    #1;
    check_all_zero("ma_async");
    @(posedge clk_i);
    #1;
    check_all_zero("ma_async_hold");
    reset_an_i = 1'b1;
    model_clear();
    cycle("ma_2", 1, 4, 1, 1);
    chk("ma.data",  32'(acc_data_o),  4);
    chk("ma.count", 32'(acc_count_o), 1);

    // Randomized traffic: short bursts, then long bursts that reach overflow.
    for (int i = 0; i < 400; i++)
      cycle("rnd_s", ($urandom % 4) != 0, $urandom_range(0, 63),
            ($urandom % 5) == 0, ($urandom % 3) != 0);
    for (int i = 0; i < 600; i++)
      cycle("rnd_l", ($urandom % 5) != 0, $urandom_range(32, 63),
            ($urandom % 24) == 0, ($urandom % 4) != 0);
    for (int i = 0; i < 4; i++) cycle("rnd_drain", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
